// File: rtl/err_compute_gen.sv
// Serial weighted right/left IR error engine: snapshot, accumulate one term per clock, saturate.
// Optional ERR_FILT_EN adds a first-order IIR (alpha = 1/4) on the delivered error.
module err_compute_gen #(
    parameter int unsigned NUM_PAIRS = 4,
    parameter int unsigned IR_W      = 12,
    parameter int unsigned ERR_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          IR_vld,
    input  logic [NUM_PAIRS*IR_W-1:0]     IR_R,
    input  logic [NUM_PAIRS*IR_W-1:0]     IR_L,
    output logic signed [ERR_W-1:0]       error,
    output logic                          err_vld,
    output logic                          busy,
    output logic                          ovr,
    output logic                          sat
);

    localparam int unsigned ACC_W = IR_W + NUM_PAIRS + 2;
    localparam int unsigned TERMS = 2 * NUM_PAIRS;
    localparam int unsigned IDX_W = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam int unsigned BUS_W = NUM_PAIRS * IR_W;
    localparam int unsigned CMP_W = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

    localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-ERR_W+1){1'b0}}, {(ERR_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-ERR_W+1){1'b1}}, {(ERR_W-1){1'b0}}};
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(TERMS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t                    state_q, state_d;
    logic [BUS_W-1:0]          snap_r_q, snap_r_d;
    logic [BUS_W-1:0]          snap_l_q, snap_l_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ERR_W-1:0]   error_d;
    logic                      err_vld_d, busy_d, ovr_d, sat_d;

    logic [IDX_W-1:0]          pair;
    logic [IR_W-1:0]           rd_sel, ld_sel;
    logic signed [ACC_W-1:0]   term;
    logic signed [CMP_W-1:0]   acc_x;
    logic signed [ERR_W-1:0]   s_val;
    logic                      clip;
    logic signed [ERR_W-1:0]   result;

    // Even index adds the right reading, odd index subtracts the left one, both weighted by 2^pair.
    always_comb begin
        pair   = idx_q >> 1;
        rd_sel = snap_r_q[pair*IR_W +: IR_W];
        ld_sel = snap_l_q[pair*IR_W +: IR_W];
        term   = ACC_W'(idx_q[0] ? ld_sel : rd_sel) << pair;
    end

    // Clamp the wide accumulator into the signed output range.
    always_comb begin
        acc_x = CMP_W'(acc_q);
        clip  = 1'b0;
        s_val = ERR_W'(acc_x);
        if (acc_x > SAT_MAX) begin
            s_val = ERR_W'(SAT_MAX);
            clip  = 1'b1;
        end else if (acc_x < SAT_MIN) begin
            s_val = ERR_W'(SAT_MIN);
            clip  = 1'b1;
        end
    end

`ifdef ERR_FILT_EN
    logic signed [ERR_W:0] diff;

    always_comb begin
        diff   = (ERR_W+1)'(s_val) - (ERR_W+1)'(error);
        result = error + ERR_W'(diff >>> 2);
    end
`else
    assign result = s_val;
`endif

    always_comb begin
        state_d   = state_q;
        snap_r_d  = snap_r_q;
        snap_l_d  = snap_l_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        error_d   = error;
        sat_d     = sat;
        err_vld_d = 1'b0;
        ovr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (IR_vld) begin
                    snap_r_d = IR_R;
                    snap_l_d = IR_L;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                ovr_d = IR_vld;
                acc_d = idx_q[0] ? (acc_q - term) : (acc_q + term);
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                ovr_d     = IR_vld;
                error_d   = result;
                sat_d     = clip;
                err_vld_d = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            snap_r_q <= '0;
            snap_l_q <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            error    <= '0;
            err_vld  <= 1'b0;
            busy     <= 1'b0;
            ovr      <= 1'b0;
            sat      <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_r_q <= snap_r_d;
            snap_l_q <= snap_l_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            error    <= error_d;
            err_vld  <= err_vld_d;
            busy     <= busy_d;
            ovr      <= ovr_d;
            sat      <= sat_d;
        end
    end

endmodule

// File: tb/tb_err_compute_gen.sv
// Randomised scoreboard bench for err_compute_gen; model follows the weighted-sum/saturate rules.
module tb_err_compute_gen;

    localparam int NP    = 4;
    localparam int IR_W  = 12;
    localparam int ERR_W = 16;
    localparam int TERMS = 2 * NP;
    localparam int BUS_W = NP * IR_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               IR_vld = 1'b0;
    logic [BUS_W-1:0]   IR_R = '0;
    logic [BUS_W-1:0]   IR_L = '0;
    logic [ERR_W-1:0]   error;
    logic               err_vld, busy, ovr, sat;

    err_compute_gen #(.NUM_PAIRS(NP), .IR_W(IR_W), .ERR_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld), .IR_R(IR_R), .IR_L(IR_L),
        .error(error), .err_vld(err_vld), .busy(busy), .ovr(ovr), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ERR_W-1:0] err;
        logic             sat;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    bit               ovr_exp[int];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_errors = 0;
    int               free_edge = 0;
    int               last_cap = 0;
    bit               have_cap = 1'b0;
    int               filt = 0;
    logic [ERR_W-1:0] err_hold = '0;
    logic             sat_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
        end
    endtask

    // Reference: signed weighted sum, clamp, optional alpha=1/4 filter.
    task automatic model(input logic [BUS_W-1:0] r, input logic [BUS_W-1:0] l, input int cap);
        int   s;
        int   lo, hi;
        bit   clipped;
        exp_t e;
        logic [IR_W-1:0] rv, lv;
        s = 0;
        for (int k = 0; k < NP; k++) begin
            rv = r[k*IR_W +: IR_W];
            lv = l[k*IR_W +: IR_W];
            s += (int'(rv) - int'(lv)) * (1 << k);
        end
        hi = (1 << (ERR_W-1)) - 1;
        lo = -(1 << (ERR_W-1));
        clipped = 1'b0;
        if (s > hi) begin s = hi; clipped = 1'b1; end
        if (s < lo) begin s = lo; clipped = 1'b1; end
`ifdef ERR_FILT_EN
        filt = filt + ((s - filt) >>> 2);
        s = filt;
`endif
        e.err = ERR_W'(s);
        e.sat = clipped;
        e.cyc = cap + TERMS + 1;
        sb.push_back(e);
    endtask

    // Drive one IR_vld strobe; called #1 after a posedge, so capture happens on the next edge.
    task automatic send(input logic [BUS_W-1:0] r, input logic [BUS_W-1:0] l);
        int e;
        e      = cyc + 1;
        IR_vld = 1'b1;
        IR_R   = r;
        IR_L   = l;
        if (e >= free_edge) begin
            model(r, l, e);
            free_edge = e + TERMS + 2;
            last_cap  = e;
            have_cap  = 1'b1;
        end else begin
            ovr_exp[e] = 1'b1;
        end
        @(posedge clk); #1;
        IR_vld = 1'b0;
        IR_R   = {$urandom, $urandom};
        IR_L   = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        ovr_exp.delete();
        have_cap  = 1'b0;
        free_edge = 0;
        filt      = 0;
        err_hold  = '0;
        sat_hold  = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
    endtask

    function automatic logic [BUS_W-1:0] fill(input int v);
        logic [BUS_W-1:0] b;
        for (int k = 0; k < NP; k++) b[k*IR_W +: IR_W] = IR_W'(v);
        return b;
    endfunction

    // Monitor: scoreboard pop on err_vld plus per-cycle busy/ovr/hold checks.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("reset_outputs", {error, err_vld, busy, ovr, sat}, '0);
        end else begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                check("err_vld_timeout", cyc, e.cyc);
            end
            if (err_vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_err_vld", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.cyc);
                    check("error", error, e.err);
                    check("sat", sat, e.sat);
                    err_hold = e.err;
                    sat_hold = e.sat;
                end
            end else begin
                check("error_hold", {error, sat}, {err_hold, sat_hold});
            end
            check("busy", busy, have_cap && cyc >= last_cap && cyc <= last_cap + TERMS);
            check("ovr", ovr, ovr_exp.exists(cyc));
        end
    end

    initial begin
        logic [BUS_W-1:0] r, l;
        int mode;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        send(BUS_W'(100) << IR_W, '0);
        idle(12);
        send(fill(2000), fill(2000));
        idle(10);
        r = fill(2000); l = fill(2000);
        r[0 +: IR_W] = '0; l[0 +: IR_W] = IR_W'(50);
        send(r, l);
        idle(10);
        send(fill(4095), '0);
        idle(10);
        send('0, fill(4095));
        idle(10);

        // Overrun three cycles after acceptance, then a strobe in the err_vld cycle.
        send(fill(123), fill(45));
        idle(2);
        send(fill(999), '0);
        idle(6);
        send(fill(7), fill(300));
        idle(12);

        // Reset in the middle of a computation.
        send(fill(1000), fill(10));
        idle(3);
        do_reset();
        send(BUS_W'(100) << IR_W, '0);
        idle(12);

        repeat (4) send(BUS_W'(400), '0) ;
        idle(40);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(BUS_W'(400), '0);
            idle(9);
        end
        idle(4);

        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 5);
            r = {$urandom, $urandom};
            l = {$urandom, $urandom};
            if (mode == 0) begin r = fill(4095); l = fill($urandom_range(0, 50)); end
            if (mode == 1) begin l = fill(4095); r = fill($urandom_range(0, 50)); end
            send(r, l);
            idle($urandom_range(0, 12));
        end
        idle(20);

        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
